// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant of whole bus cycles between
// the JTAG and CPU masters, with a watchdog that aborts stalled strobes.
module wb_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam bit WD_ON = (TIMEOUT != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t          state_r;
    logic            gnt_r;
    logic            last_r;
    logic [WD_W-1:0] wd_r;

    logic gnt_cyc_s;
    logic gnt_stb_s;
    logic winner_s;
    logic stall_s;
    logic expire_s;

    // Arbitration winner and watchdog expiry decode
    always_comb begin
        gnt_cyc_s = gnt_r ? m1_cyc_i : m0_cyc_i;
        gnt_stb_s = gnt_r ? m1_stb_i : m0_stb_i;
        if (m0_cyc_i && m1_cyc_i) begin
            winner_s = ~last_r;
        end else if (m1_cyc_i) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        stall_s  = (state_r == ST_GRANT) && gnt_stb_s && !wb_ack_i;
        expire_s = WD_ON && stall_s && (wd_r == WD_LAST);
    end

    // Slave-side mux from the granted master and response routing back to it
    always_comb begin
        wb_adr_o = 32'd0;
        wb_dat_o = 32'd0;
        wb_sel_o = 4'd0;
        wb_we_o  = 1'b0;
        wb_stb_o = 1'b0;
        wb_cyc_o = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        if (state_r == ST_GRANT) begin
            if (gnt_r) begin
                wb_adr_o = m1_adr_i;
                wb_dat_o = m1_dat_i;
                wb_sel_o = m1_sel_i;
                wb_we_o  = m1_we_i;
                wb_stb_o = m1_stb_i;
                wb_cyc_o = m1_cyc_i;
                m1_ack_o = wb_ack_i;
                m1_err_o = expire_s;
            end else begin
                wb_adr_o = m0_adr_i;
                wb_dat_o = m0_dat_i;
                wb_sel_o = m0_sel_i;
                wb_we_o  = m0_we_i;
                wb_stb_o = m0_stb_i;
                wb_cyc_o = m0_cyc_i;
                m0_ack_o = wb_ack_i;
                m0_err_o = expire_s;
            end
        end else begin
            // IDLE and ABORT keep the slave bus released
            wb_stb_o = 1'b0;
            wb_cyc_o = 1'b0;
        end
    end

    assign m0_dat_o = wb_dat_i;
    assign m1_dat_o = wb_dat_i;

    // Bus-ownership state machine with watchdog counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
            gnt_r   <= 1'b0;
            last_r  <= 1'b1;
            wd_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        state_r <= ST_GRANT;
                        gnt_r   <= winner_s;
                        last_r  <= winner_s;
                        wd_r    <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!gnt_cyc_s) begin
                        state_r <= ST_IDLE;
                    end else if (expire_s) begin
                        state_r <= ST_ABORT;
                    end else begin
                        state_r <= ST_GRANT;
                    end
                    // Any ack or idle strobe restarts the stall count
                    if (stall_s) begin
                        wd_r <= wd_r + WD_W'(1);
                    end else begin
                        wd_r <= '0;
                    end
                end
                ST_ABORT: begin
                    if (!gnt_cyc_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ABORT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: two instances (watchdog 8 and watchdog disabled) share
// stimulus; a bus-ownership reference model predicts every output each cycle.
module tb_wb_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] adr[2];
    logic [31:0] wdat[2];
    logic [3:0]  sel[2];
    logic        we[2];
    logic        stb[2];
    logic        cyc[2];
    logic [31:0] sdat;
    logic        sack;

    logic [31:0] o_md0[2], o_md1[2], o_adr[2], o_dat[2];
    logic [3:0]  o_sel[2];
    logic        o_ack0[2], o_ack1[2], o_err0[2], o_err1[2];
    logic        o_we[2], o_stb[2], o_cyc[2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        wb_arbiter #(.TIMEOUT((k == 0) ? 8 : 0)) dut (
            .sys_clk (clk),
            .sys_rst (rst),
            .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]),
            .m0_we_i (we[0]),  .m0_stb_i(stb[0]),  .m0_cyc_i(cyc[0]),
            .m0_dat_o(o_md0[k]), .m0_ack_o(o_ack0[k]), .m0_err_o(o_err0[k]),
            .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]),
            .m1_we_i (we[1]),  .m1_stb_i(stb[1]),  .m1_cyc_i(cyc[1]),
            .m1_dat_o(o_md1[k]), .m1_ack_o(o_ack1[k]), .m1_err_o(o_err1[k]),
            .wb_adr_o(o_adr[k]), .wb_dat_o(o_dat[k]), .wb_sel_o(o_sel[k]),
            .wb_we_o (o_we[k]),  .wb_stb_o(o_stb[k]), .wb_cyc_o(o_cyc[k]),
            .wb_dat_i(sdat),     .wb_ack_i(sack)
        );
    end

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: owner (-1 = bus free), aborted flag, last winner, stall run length
    int own[2];
    bit dead[2];
    int lst[2];
    int stall[2];
    int to_v[2] = '{8, 0};

    task automatic check_val(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [159:0] act_out(input int k);
        return {21'd0, o_adr[k], o_dat[k], o_sel[k], o_we[k], o_stb[k], o_cyc[k],
                o_ack0[k], o_ack1[k], o_err0[k], o_err1[k], o_md0[k], o_md1[k]};
    endfunction

    function automatic bit model_err(input int k);
        int g;
        if (own[k] < 0 || dead[k] || to_v[k] == 0) return 1'b0;
        g = own[k];
        return stb[g] && !sack && (stall[k] == to_v[k] - 1);
    endfunction

    function automatic logic [159:0] exp_out(input int k);
        logic [31:0] a, d;
        logic [3:0]  s;
        logic w, sb, cy;
        logic [1:0] ack, err;
        int g;
        a = 32'd0; d = 32'd0; s = 4'd0; w = 1'b0; sb = 1'b0; cy = 1'b0;
        ack = 2'b00; err = 2'b00;
        if (own[k] >= 0 && !dead[k]) begin
            g = own[k];
            a = adr[g]; d = wdat[g]; s = sel[g]; w = we[g]; sb = stb[g]; cy = cyc[g];
            ack[g] = sack;
            err[g] = model_err(k);
        end
        return {21'd0, a, d, s, w, sb, cy, ack[0], ack[1], err[0], err[1], sdat, sdat};
    endfunction

    task automatic model_next(input int k);
        int g;
        bit e;
        if (rst) begin
            own[k] = -1; dead[k] = 1'b0; lst[k] = 1; stall[k] = 0;
        end else if (own[k] < 0) begin
            if (cyc[0] || cyc[1]) begin
                g = (cyc[0] && cyc[1]) ? 1 - lst[k] : (cyc[1] ? 1 : 0);
                own[k] = g; lst[k] = g; stall[k] = 0;
            end
        end else begin
            g = own[k];
            if (!cyc[g]) begin
                own[k] = -1; dead[k] = 1'b0;
            end else if (!dead[k]) begin
                e = model_err(k);
                if (e) dead[k] = 1'b1;
                stall[k] = (stb[g] && !sack) ? stall[k] + 1 : 0;
            end
        end
    endtask

    task automatic settle();
        #4;
        if (chk_en) begin
            check_val("out_to8", act_out(0), exp_out(0));
            check_val("out_to0", act_out(1), exp_out(1));
        end
    endtask

    task automatic tick();
        model_next(0);
        model_next(1);
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
        end
        sack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int g, w, first, npulse, nbad, nrel, div;
        rst = 1'b1; sdat = 32'd0; sack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            adr[i] = 32'd0; wdat[i] = 32'd0; sel[i] = 4'd0;
            we[i] = 1'b0; stb[i] = 1'b0; cyc[i] = 1'b0;
        end
        cycle();
        chk_en = 1'b1;

        // Reset state: every output zero
        do_reset();
        settle();
        check_val("reset_out8", act_out(0), 160'd0);
        check_val("reset_out0", act_out(1), 160'd0);
        tick();

        // Single master read
        adr[0] = 32'h0000_0010; sel[0] = 4'hF; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
        settle();
        check_val("grant_lat", 160'(o_cyc[0]), 160'd0);
        tick();
        settle();
        check_val("grant_cyc", 160'(o_cyc[0]), 160'd1);
        check_val("grant_adr", 160'(o_adr[0]), 160'h10);
        tick();
        cycle();
        sack = 1'b1; sdat = 32'hDEAD_BEEF;
        settle();
        check_val("rd_ack0", 160'(o_ack0[0]), 160'd1);
        check_val("rd_dat0", 160'(o_md0[0]), 160'hDEAD_BEEF);
        check_val("rd_ack1", 160'(o_ack1[0]), 160'd0);
        tick();
        idle_all();
        cycle();

        // Contention from reset: m0 first, m1 two cycles after m0 drops
        do_reset();
        adr[0] = 32'hA000_0000; adr[1] = 32'hB000_0000;
        cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        cycle();
        settle();
        check_val("cont_first", 160'(o_adr[0]), 160'hA000_0000);
        tick();
        cycle();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        cycle();
        settle();
        check_val("cont_gap", 160'(o_cyc[0]), 160'd0);
        tick();
        settle();
        check_val("cont_second", 160'(o_adr[0]), 160'hB000_0000);
        tick();
        idle_all();
        cycle();

        // Fairness: both always requesting, each holds its grant 6 cycles
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = 0;
            settle();
            while (!o_cyc[0] && w < 4) begin
                tick();
                settle();
                w++;
            end
            check_val("fair_granted", 160'(o_cyc[0]), 160'd1);
            g = (o_adr[0] == adr[1]) ? 1 : 0;
            check_val("fair_order", 160'(g), 160'(i % 2));
            tick();
            repeat (5) cycle();
            cyc[g] = 1'b0; stb[g] = 1'b0;
            cycle();
            cyc[g] = 1'b1; stb[g] = 1'b1;
        end
        idle_all();
        cycle();
        cycle();

        // Watchdog (TIMEOUT=8): stalled write to unmapped address
        do_reset();
        adr[1] = 32'hBAD0_0000; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        cycle();
        first = -1; npulse = 0;
        for (int off = 0; off < 12; off++) begin
            settle();
            if (o_err1[0]) begin
                npulse++;
                if (first < 0) first = off;
            end
            if (off == 8) check_val("wd_drop", 160'(o_cyc[0]), 160'd0);
            tick();
        end
        check_val("wd_err_cycle", 160'(first), 160'd7);
        check_val("wd_err_pulses", 160'(npulse), 160'd1);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        adr[0] = 32'h0000_0400; cyc[0] = 1'b1; stb[0] = 1'b1;
        cycle();
        cycle();
        settle();
        check_val("wd_next_master", 160'(o_adr[0]), 160'h400);
        tick();
        idle_all();
        cycle();
        cycle();
        // Ack coincident with expiry: ack wins
        cyc[1] = 1'b1; stb[1] = 1'b1;
        cycle();
        repeat (7) cycle();
        sack = 1'b1;
        settle();
        check_val("wd_ack_wins", 160'(o_ack1[0]), 160'd1);
        check_val("wd_no_err", 160'(o_err1[0]), 160'd0);
        tick();
        sack = 1'b0;
        settle();
        check_val("wd_ack_held", 160'(o_cyc[0]), 160'd1);
        tick();
        idle_all();
        cycle();

        // Reset while m1 granted and waiting
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1; sdat = 32'd0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        settle();
        check_val("rst_mid_out", act_out(0), 160'd0);
        tick();
        settle();
        check_val("rst_mid_winner", 160'(o_adr[0]), 160'h400);
        tick();
        idle_all();
        cycle();

        // Watchdog disabled: 5000-cycle stall, then normal ack
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        cycle();
        nbad = 0; nrel = 0;
        for (int c = 0; c < 5000; c++) begin
            settle();
            if (o_err0[1] || o_err1[1]) nbad++;
            if (!o_cyc[1]) nrel++;
            tick();
        end
        check_val("to0_no_err", 160'(nbad), 160'd0);
        check_val("to0_held", 160'(nrel), 160'd0);
        sack = 1'b1;
        settle();
        check_val("to0_ack", 160'(o_ack0[1]), 160'd1);
        tick();
        idle_all();
        cycle();

        // Randomized traffic against the model
        do_reset();
        div = 2;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) div = ($urandom % 2 == 0) ? 2 : 30;
            for (int i = 0; i < 2; i++) begin
                if ($urandom % 16 == 0) cyc[i] = ~cyc[i];
                stb[i]  = cyc[i] && ($urandom % 8 != 0);
                adr[i]  = $urandom;
                wdat[i] = $urandom;
                sel[i]  = 4'($urandom);
                we[i]   = 1'($urandom);
            end
            sack = ($urandom % div == 0);
            sdat = $urandom;
            rst  = ($urandom % 500 == 0);
            cycle();
        end
        rst = 1'b0;
        idle_all();
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master Wishbone arbiter that shares the single system bus between the JTAG memory-access master and the CPU data master. It sits between the masters and the interconnect/slave decoder. It grants whole bus cycles (held for as long as `cyc` is high) with round-robin fairness. A watchdog terminates stalled cycles with an error so that a missing slave cannot hang either master.

## Interface
- `TIMEOUT`, 1024: stalled-strobe cycles before abort; 0 disables the watchdog; counter width `$clog2(TIMEOUT+1)`.
- `sys_clk` in 1: single clock; all state on rising edge.
- `sys_rst` in 1: reset is synchronous and active-high.
- `m0_adr_i`, `m1_adr_i` in 32: master address.
- `m0_dat_i`, `m1_dat_i` in 32: master write data.
- `m0_sel_i`, `m1_sel_i` in 4: master byte selects.
- `m0_we_i`, `m1_we_i` in 1: master write enable.
- `m0_stb_i`, `m1_stb_i` in 1: master strobe.
- `m0_cyc_i`, `m1_cyc_i` in 1: master cycle / bus request.
- `m0_dat_o`, `m1_dat_o` out 32: read data, both equal to `wb_dat_i` at all times.
- `m0_ack_o`, `m1_ack_o` out 1: acknowledge, routed to the granted master only.
- `m0_err_o`, `m1_err_o` out 1: watchdog abort pulse to the granted master.
- `wb_adr_o` out 32, `wb_dat_o` out 32, `wb_sel_o` out 4, `wb_we_o` out 1, `wb_stb_o` out 1, `wb_cyc_o` out 1: slave-side bus.
- `wb_dat_i` in 32, `wb_ack_i` in 1: slave-side response.

## Operation
- Registered state: `state` ∈ {IDLE, GRANT, ABORT}, `gnt` (granted master index), `last` (last granted index), `wd` (watchdog count).
- IDLE: no master drives the bus. All `wb_*_o` = 0; all `m*_ack_o`/`m*_err_o` = 0.
- IDLE → GRANT when any `m*_cyc_i` = 1:
  - Only one master requesting: grant it.
  - Both requesting: grant `!last`.
  - On the transition, `gnt` and `last` are set to the winner and `wd` is cleared.
- GRANT, slave-side outputs: `wb_adr_o`/`wb_dat_o`/`wb_sel_o`/`wb_we_o`/`wb_stb_o` mux combinationally from master `gnt`; `wb_cyc_o` = `m[gnt]_cyc_i`.
- GRANT, responses: `m[gnt]_ack_o` = `wb_ack_i`; the other master's ack = 0.
- GRANT, watchdog: while `wb_stb_o & ~wb_ack_i`, `wd` increments; any ack, or `stb` low, clears `wd`.
- GRANT, abort: when `TIMEOUT` ≠ 0 and `wd` = `TIMEOUT-1` with `wb_stb_o & ~wb_ack_i`:
  - `m[gnt]_err_o` = 1 that cycle (combinational).
  - Next state is ABORT.
- GRANT → IDLE when `m[gnt]_cyc_i` = 0, including in the same cycle as an ack. The other master is considered from IDLE on the following cycle.
- ABORT:
  - `wb_cyc_o` = `wb_stb_o` = 0; other slave outputs as IDLE.
  - Acks are not forwarded; `m*_err_o` = 0.
  - Stays in ABORT until `m[gnt]_cyc_i` = 0, then goes to IDLE.
- Reset values: `state` = IDLE, `gnt` = 0, `last` = 1 (master 0 wins the first contended arbitration), `wd` = 0. All outputs 0 after the reset edge.
- Reset mid-cycle: the bus is released at the reset edge and no ack/err is produced. The master sees its cycle vanish, and the transfer is not retried.
- The non-granted master's `stb`/`cyc` have no effect on the bus or on its own ack; it waits with `cyc` held.

## Timing
- Grant latency: `cyc` seen in IDLE at edge N → `wb_cyc_o`/`wb_stb_o` visible after edge N (cycle N+1). One-cycle arbitration cost per bus cycle.
- Ack path is combinational slave → master. Zero added latency once granted.
- Handoff: granted master drops `cyc` at cycle K → IDLE in K+1 → waiting master granted, bus visible in K+2.
- Watchdog: with `stb` asserted and no ack starting in cycle S, `err` is asserted in cycle S+TIMEOUT-1 and the slave bus drops in cycle S+TIMEOUT.
- Simultaneous `wb_ack_i` and watchdog expiry: ack wins. Ack is forwarded, no `err`, `wd` cleared.
- Back-to-back requests from the same master, with the other idle: one IDLE cycle between cycles, then the same master is re-granted.

## Test plan
- Single master: m0 reads `0x00000010`, slave acks 2 cycles after `stb` with `0xDEADBEEF` → `wb_cyc_o` rises 1 cycle after `m0_cyc_i`; `m0_ack_o` is coincident with `wb_ack_i`; `m0_dat_o` = `0xDEADBEEF`; `m1_ack_o` stays 0.
- Contention from reset: m0 and m1 raise `cyc` in the same cycle → m0 granted first. After m0 drops `cyc`, m1 is granted 2 cycles later (its address appears on `wb_adr_o`).
- Fairness: both hold requests continuously for 6 cycles each → grant order m0, m1, m0, m1, m0, m1; neither is granted twice in a row while the other waits.
- Watchdog: `TIMEOUT`=8, m1 writes to an unmapped address with no ack → `m1_err_o` pulses exactly once, 7 cycles after `stb`, and `wb_cyc_o` = 0 from the next cycle. After m1 drops `cyc`, m0 is grantable. Repeat with ack in the expiry cycle → ack only, no err.
- Reset mid-operation: assert `sys_rst` for 1 cycle while m1 is granted and awaiting ack → all outputs 0 after the edge. With both then requesting, m0 wins.
- `TIMEOUT`=0: stall for 5000 cycles → no err, grant held, ack after the stall completes the cycle normally.
